// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Per-channel PLL reset/lock sequencer with debounce, retry on
//               timeout, saturating loss counters and a global system reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int N_CH          = 2,
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 1000000,
    parameter int STABLE_CYCLES = 1024,
    parameter int CNT_W         = 24,
    parameter int LOSS_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          pll_lock_i,
    input  logic                     clr_i,
    output logic [N_CH-1:0]          pll_rst_o,
    output logic [N_CH-1:0]          locked_o,
    output logic                     all_locked_o,
    output logic                     sys_rst_o,
    output logic [N_CH-1:0]          timeout_o,
    output logic [N_CH*LOSS_W-1:0]   loss_cnt_o
);

    localparam longint c_max_cycles =
        (RST_CYCLES >= LOCK_TIMEOUT && RST_CYCLES >= STABLE_CYCLES) ? longint'(RST_CYCLES) :
        (LOCK_TIMEOUT >= STABLE_CYCLES)                             ? longint'(LOCK_TIMEOUT) :
                                                                      longint'(STABLE_CYCLES);
    localparam longint c_timer_lim = (longint'(1) << CNT_W) - 1;

    if (c_max_cycles > c_timer_lim || RST_CYCLES < 1 || LOCK_TIMEOUT < 2 ||
        STABLE_CYCLES < 1) begin : g_param_check
        $error("pll_lock_supervisor: illegal cycle parameters or CNT_W too small");
    end

    localparam logic [CNT_W-1:0]  c_rst_last    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_tmo_last    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  c_stable_last = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_timer_max   = '1;
    localparam logic [LOSS_W-1:0] c_loss_max    = '1;

    typedef enum logic [1:0] {
        ST_RESET_PLL = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABILIZE = 2'd2,
        ST_LOCKED    = 2'd3
    } state_t;

    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    logic            r_all_locked;
    logic            r_sys_rst;

    // Raw lock is asynchronous to clk; only the second flop feeds the FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pll_lock_i;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_t            r_state;
        state_t            w_state_nxt;
        logic [CNT_W-1:0]  r_timer;
        logic [CNT_W-1:0]  w_timer_nxt;
        logic [CNT_W-1:0]  w_timer_inc;
        logic [LOSS_W-1:0] r_loss;
        logic              r_timeout;
        logic              w_lk;
        logic              w_loss_evt;
        logic              w_timeout_evt;

        assign w_lk        = r_sync2[k];
        assign w_timer_inc = (r_timer == c_timer_max) ? r_timer : r_timer + CNT_W'(1);

        always_comb begin
            w_state_nxt   = r_state;
            w_timer_nxt   = w_timer_inc;
            w_loss_evt    = 1'b0;
            w_timeout_evt = 1'b0;
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_timer >= c_rst_last) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (w_lk) begin
                        w_state_nxt = ST_STABILIZE;
                        w_timer_nxt = '0;
                    end else if (r_timer >= c_tmo_last) begin
                        w_state_nxt   = ST_RESET_PLL;
                        w_timer_nxt   = '0;
                        w_timeout_evt = 1'b1;
                    end
                end
                // Timer counts consecutive high-lock cycles seen in this state.
                ST_STABILIZE: begin
                    if (!w_lk) begin
                        w_state_nxt = ST_WAIT_LOCK;
                        w_timer_nxt = '0;
                    end else if (r_timer >= c_stable_last) begin
                        w_state_nxt = ST_LOCKED;
                        w_timer_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!w_lk) begin
                        w_state_nxt = ST_RESET_PLL;
                        w_timer_nxt = '0;
                        w_loss_evt  = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_RESET_PLL;
                    w_timer_nxt = '0;
                end
            endcase
        end

        // A loss/timeout event coinciding with clr_i takes precedence.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_state   <= ST_RESET_PLL;
                r_timer   <= '0;
                r_loss    <= '0;
                r_timeout <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_timer   <= w_timer_nxt;
                r_timeout <= w_timeout_evt | (r_timeout & ~clr_i);
                if (clr_i) begin
                    r_loss <= w_loss_evt ? LOSS_W'(1) : '0;
                end else if (w_loss_evt && (r_loss != c_loss_max)) begin
                    r_loss <= r_loss + LOSS_W'(1);
                end
            end
        end

        assign pll_rst_o[k]                     = (r_state == ST_RESET_PLL);
        assign locked_o[k]                      = (r_state == ST_LOCKED);
        assign timeout_o[k]                     = r_timeout;
        assign loss_cnt_o[k*LOSS_W +: LOSS_W]   = r_loss;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_all_locked <= 1'b0;
            r_sys_rst    <= 1'b1;
        end else begin
            r_all_locked <= &locked_o;
            r_sys_rst    <= ~r_all_locked;
        end
    end

    assign all_locked_o = r_all_locked;
    assign sys_rst_o    = r_sys_rst;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Scoreboard bench for pll_lock_supervisor with a cycle-based
//               reference model and directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int c_n     = 2;
    localparam int c_rst   = 4;
    localparam int c_tmo   = 20;
    localparam int c_stb   = 8;
    localparam int c_cnt_w = 8;
    localparam int c_loss  = 2;

    localparam int M_RST  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_LOCK = 3;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [c_n-1:0]          pll_lock_i = '0;
    logic                    clr_i = 1'b0;
    logic [c_n-1:0]          pll_rst_o;
    logic [c_n-1:0]          locked_o;
    logic                    all_locked_o;
    logic                    sys_rst_o;
    logic [c_n-1:0]          timeout_o;
    logic [c_n*c_loss-1:0]   loss_cnt_o;

    always #5 clk = ~clk;

    pll_lock_supervisor #(
        .N_CH(c_n), .RST_CYCLES(c_rst), .LOCK_TIMEOUT(c_tmo),
        .STABLE_CYCLES(c_stb), .CNT_W(c_cnt_w), .LOSS_W(c_loss)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock_i(pll_lock_i), .clr_i(clr_i),
        .pll_rst_o(pll_rst_o), .locked_o(locked_o), .all_locked_o(all_locked_o),
        .sys_rst_o(sys_rst_o), .timeout_o(timeout_o), .loss_cnt_o(loss_cnt_o)
    );

    int errors = 0;
    int checks = 0;
    logic [11:0] exp_q[$];

    // Reference model: each channel remembers its phase and the cycle it entered it.
    int m_cyc = 0;
    int m_mode[c_n];
    int m_enter[c_n];
    bit m_s1[c_n];
    bit m_s2[c_n];
    bit m_tmo[c_n];
    int m_loss[c_n];
    bit m_all = 1'b0;
    bit m_sys = 1'b1;

    task automatic model_step();
        bit old_all;
        bit lk;
        bit ev_loss;
        bit ev_tmo;
        int n;
        logic [11:0] e;
        m_cyc++;
        if (rst) begin
            for (int c = 0; c < c_n; c++) begin
                m_mode[c] = M_RST; m_enter[c] = m_cyc; m_s1[c] = 0; m_s2[c] = 0;
                m_tmo[c] = 0; m_loss[c] = 0;
            end
            m_all = 0;
            m_sys = 1;
        end else begin
            old_all = (m_mode[0] == M_LOCK) && (m_mode[1] == M_LOCK);
            m_sys = !m_all;
            m_all = old_all;
            for (int c = 0; c < c_n; c++) begin
                lk = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = pll_lock_i[c];
                n = m_cyc - m_enter[c];
                ev_loss = 0;
                ev_tmo = 0;
                case (m_mode[c])
                    M_RST:  if (n >= c_rst) begin m_mode[c] = M_WAIT; m_enter[c] = m_cyc; end
                    M_WAIT: if (lk) begin m_mode[c] = M_STAB; m_enter[c] = m_cyc; end
                            else if (n >= c_tmo) begin
                                m_mode[c] = M_RST; m_enter[c] = m_cyc; ev_tmo = 1;
                            end
                    M_STAB: if (!lk) begin m_mode[c] = M_WAIT; m_enter[c] = m_cyc; end
                            else if (n >= c_stb) m_mode[c] = M_LOCK;
                    default: if (!lk) begin
                                m_mode[c] = M_RST; m_enter[c] = m_cyc; ev_loss = 1;
                            end
                endcase
                if (clr_i) m_loss[c] = ev_loss ? 1 : 0;
                else if (ev_loss && m_loss[c] < 3) m_loss[c]++;
                m_tmo[c] = ev_tmo || (m_tmo[c] && !clr_i);
            end
        end
        e = {m_mode[1] == M_RST, m_mode[0] == M_RST, m_mode[1] == M_LOCK, m_mode[0] == M_LOCK,
             m_all, m_sys, m_tmo[1], m_tmo[0], 2'(m_loss[1]), 2'(m_loss[0])};
        exp_q.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: every cycle the DUT presents a full output set; compare to the queue head.
    initial forever begin
        logic [11:0] e;
        logic [11:0] act;
        @(negedge clk);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: actual none required one entry");
        end else begin
            e = exp_q.pop_front();
            act = {pll_rst_o, locked_o, all_locked_o, sys_rst_o, timeout_o, loss_cnt_o};
            if (act !== e) begin
                errors++;
                $display("FAIL outputs cycle %0d: actual %h required %h", m_cyc, act, e);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic wait_all_locked(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (all_locked_o) break;
        end
        check("wait_all_locked", 32'(all_locked_o), 32'd1);
    endtask

    task automatic wait_pll_rst1(input logic val, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pll_rst_o[1] == val) break;
        end
        check("wait_pll_rst1", 32'(pll_rst_o[1]), 32'(val));
    endtask

    initial begin
        int first_prst;
        int first_lock;
        int first_rel;
        int r;
        int rises[$];
        logic prev;

        repeat (3) @(negedge clk);
        check("reset_pll_rst", 32'(pll_rst_o), 32'h3);
        check("reset_locked", 32'(locked_o), 32'h0);
        check("reset_sys_rst", 32'(sys_rst_o), 32'h1);
        check("reset_cnt_tmo", 32'({all_locked_o, timeout_o, loss_cnt_o}), 32'h0);

        // Scenario 1: clean lock on both channels from release.
        rst = 1'b0;
        pll_lock_i = 2'b11;
        first_prst = 0; first_lock = 0; first_rel = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk); #1;
            if (pll_rst_o == 2'b00 && first_prst == 0) first_prst = i;
            if (locked_o == 2'b11 && first_lock == 0) first_lock = i;
            if (!sys_rst_o && first_rel == 0) first_rel = i;
        end
        check("t1_pll_rst_release", 32'(first_prst), 32'd4);
        check("t1_locked_cycle", 32'(first_lock), 32'd13);
        check("t1_sys_rst_release", 32'(first_rel), 32'd15);

        // Scenario 2: ch0 never locks, retries every RST+TIMEOUT cycles.
        @(negedge clk);
        pll_lock_i[0] = 1'b0;
        prev = pll_rst_o[0];
        for (int i = 1; i <= 80; i++) begin
            @(posedge clk); #1;
            if (pll_rst_o[0] && !prev) rises.push_back(i);
            prev = pll_rst_o[0];
        end
        check("t2_rise_count_ge3", 32'(rises.size() >= 3), 32'd1);
        if (rises.size() > 0) check("t2_first_rise", 32'(rises[0]), 32'd3);
        for (int j = 1; j < rises.size(); j++)
            check("t2_repulse_period", 32'(rises[j] - rises[j-1]), 32'd24);
        check("t2_timeout0", 32'(timeout_o), 32'h1);
        check("t2_ch1_locked", 32'(locked_o[1]), 32'd1);
        check("t2_sys_rst_held", 32'(sys_rst_o), 32'd1);
        @(negedge clk);
        pll_lock_i[0] = 1'b1;
        wait_all_locked(100);

        // Scenario 3: ch1 one-cycle glitch while stabilising.
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0; pll_lock_i[1] = 1'b0;
        @(negedge clk);
        @(negedge clk); pll_lock_i[1] = 1'b1;
        wait_pll_rst1(1'b1, 20);
        wait_pll_rst1(1'b0, 20);
        r = $urandom_range(0, 5);
        repeat (r + 1) @(negedge clk);
        pll_lock_i[1] = 1'b0;
        first_lock = 0;
        @(posedge clk); #1;
        @(negedge clk); pll_lock_i[1] = 1'b1;
        for (int i = 2; i <= 40; i++) begin
            @(posedge clk); #1;
            if (locked_o[1] && first_lock == 0) first_lock = i;
        end
        check("t3_relock_after_glitch", 32'(first_lock), 32'd12);
        check("t3_loss_cnt", 32'(loss_cnt_o), 32'h4);

        // Scenario 4: five losses on ch0 saturate its counter.
        for (int t = 0; t < 5; t++) begin
            @(negedge clk); pll_lock_i[0] = 1'b0;
            repeat (3) @(negedge clk);
            pll_lock_i[0] = 1'b1;
            wait_all_locked(100);
        end
        check("t4_loss0_saturated", 32'(loss_cnt_o[1:0]), 32'd3);
        check("t4_loss1_kept", 32'(loss_cnt_o[3:2]), 32'd1);

        // Scenario 5: clear coinciding with a loss, then a plain clear.
        @(negedge clk); pll_lock_i[0] = 1'b0;
        @(negedge clk);
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0;
        check("t5_clr_with_loss", 32'(loss_cnt_o), 32'h1);
        pll_lock_i[0] = 1'b1;
        wait_all_locked(100);
        @(negedge clk); clr_i = 1'b1;
        @(negedge clk); clr_i = 1'b0;
        check("t5_plain_clr", 32'({timeout_o, loss_cnt_o}), 32'h0);

        // Scenario 6: reset while both channels are locked.
        @(negedge clk); pll_lock_i[0] = 1'b0;
        repeat (3) @(negedge clk);
        pll_lock_i[0] = 1'b1;
        wait_all_locked(100);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("t6_locked", 32'(locked_o), 32'h0);
        check("t6_pll_rst", 32'(pll_rst_o), 32'h3);
        check("t6_sys_rst", 32'(sys_rst_o), 32'h1);
        check("t6_counters", 32'({all_locked_o, timeout_o, loss_cnt_o}), 32'h0);
        @(negedge clk); rst = 1'b0;

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            for (int c = 0; c < c_n; c++)
                if ($urandom_range(0, 15) == 0) pll_lock_i[c] = ~pll_lock_i[c];
            clr_i = ($urandom_range(0, 24) == 0);
            rst = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        rst = 1'b0;
        clr_i = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
